// File: rtl/ezusb_tx_framer.sv
// Store-and-forward frame builder for an EZ-USB slave FIFO: buffers one frame, then emits
// header, length, payload (and a checksum trailer when TX_FRAMER_CSUM_EN is defined), then arms PKTEND.
module ezusb_tx_framer #(
  parameter int         DEPTH_LOG2 = 9,
  parameter logic [7:0] SYNC_WORD  = 8'hA5
) (
  input  logic        ifclk,
  input  logic        reset_n,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  input  logic        src_last,
  input  logic [3:0]  src_tag,
  output logic        src_ready,
  output logic [15:0] DI,
  output logic        DI_valid,
  input  logic        DI_ready,
  output logic        pktend_arm,
  input  logic        PKTEND,
  output logic [15:0] frame_cnt,
  output logic        trunc
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;

  // Handshakes: a word moves on any rising ifclk edge where valid && ready; the sender
  // holds data and valid stable until that edge, and valid never depends on ready.
  typedef enum logic [2:0] {
    FILL,
    HDR,
    LEN,
    DATA,
`ifdef TX_FRAMER_CSUM_EN
    CSUM,
`endif
    ARM,
    WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    rst_sync;
  logic          rst_ok;
  logic [15:0]   mem [N];
  logic [CW-1:0] wcnt;
  logic [CW-1:0] len_q;
  logic [CW-1:0] rptr;
  logic [3:0]    tag_q;
  logic [15:0]   rd_data;
  logic          accept;
  logic          fire;
  logic          full;
  logic          last_data;
  logic          load;
  logic          wait_done;

  // src_ready is held off until the release of reset has passed two flops.
  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_ok = rst_sync[1];

  assign src_ready = (state == FILL) && rst_ok;
  assign accept    = src_valid && src_ready;
  assign fire      = DI_valid && DI_ready;
  assign full      = (wcnt == CW'(N - 1));
  assign last_data = (rptr == len_q);
  assign wait_done = (state == WAIT) && !PKTEND;
  // rptr always points one past the word on DI, so the next word is already in rd_data.
  assign load      = fire && ((state == HDR) || (state == DATA));

  always_ff @(posedge ifclk) begin
    if (accept) mem[wcnt[DEPTH_LOG2-1:0]] <= src_data;
  end

  always_ff @(posedge ifclk) begin
    if (load) rd_data <= mem[rptr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      wcnt      <= '0;
      len_q     <= '0;
      rptr      <= '0;
      tag_q     <= 4'h0;
      frame_cnt <= 16'h0;
      trunc     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == '0) tag_q <= src_tag;
        if (src_last || full) len_q <= wcnt + 1'b1;
        if (full && !src_last) trunc <= 1'b1;
      end
      if (load) rptr <= rptr + 1'b1;
      if (wait_done) begin
        frame_cnt <= frame_cnt + 16'h1;
        wcnt      <= '0;
        rptr      <= '0;
      end
    end
  end

`ifdef TX_FRAMER_CSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n)    csum_q <= 16'h0;
    else if (accept) csum_q <= (wcnt == '0) ? src_data : csum_q + src_data;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && (src_last || full)) state_nxt = HDR;
      HDR:  if (fire) state_nxt = LEN;
      LEN:  if (fire) state_nxt = DATA;
`ifdef TX_FRAMER_CSUM_EN
      DATA: if (fire && last_data) state_nxt = CSUM;
      CSUM: if (fire) state_nxt = ARM;
`else
      DATA: if (fire && last_data) state_nxt = ARM;
`endif
      ARM:  state_nxt = WAIT;
      WAIT: if (!PKTEND) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    DI         = 16'h0;
    DI_valid   = 1'b0;
    pktend_arm = 1'b0;
    case (state)
      HDR: begin
        DI       = {SYNC_WORD, 4'h0, tag_q};
        DI_valid = 1'b1;
      end
      LEN: begin
        DI       = 16'(len_q);
        DI_valid = 1'b1;
      end
      DATA: begin
        DI       = rd_data;
        DI_valid = 1'b1;
      end
`ifdef TX_FRAMER_CSUM_EN
      CSUM: begin
        DI       = csum_q;
        DI_valid = 1'b1;
      end
`endif
      ARM:     pktend_arm = 1'b1;
      WAIT:    pktend_arm = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ezusb_tx_framer.sv
// Directed bench for ezusb_tx_framer (4-word buffer); trailer words are expected only when
// TX_FRAMER_CSUM_EN is defined.
module tb_ezusb_tx_framer;

  logic        ifclk = 1'b0;
  logic        reset_n;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_last;
  logic [3:0]  src_tag;
  logic        src_ready;
  logic [15:0] DI;
  logic        DI_valid;
  logic        DI_ready;
  logic        pktend_arm;
  logic        PKTEND;
  logic [15:0] frame_cnt;
  logic        trunc;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic bp_en    = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int   bp_i     = 0;
  int   arm_rises = 0;
  logic arm_prev  = 1'b0;
  int   rises0;

  ezusb_tx_framer #(.DEPTH_LOG2(2), .SYNC_WORD(8'hA5)) dut (
    .ifclk      (ifclk),
    .reset_n    (reset_n),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_last   (src_last),
    .src_tag    (src_tag),
    .src_ready  (src_ready),
    .DI         (DI),
    .DI_valid   (DI_valid),
    .DI_ready   (DI_ready),
    .pktend_arm (pktend_arm),
    .PKTEND     (PKTEND),
    .frame_cnt  (frame_cnt),
    .trunc      (trunc)
  );

  always #5 ifclk = ~ifclk;

  always @(posedge ifclk) begin
    if (pktend_arm && !arm_prev) arm_rises++;
    arm_prev = pktend_arm;
  end

  task automatic check(input string nm, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", nm, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic l, input logic [3:0] t);
    int n = 0;
    src_data  = d;
    src_last  = l;
    src_tag   = t;
    src_valid = 1'b1;
    while (!src_ready && n < 200) begin
      @(negedge ifclk);
      n++;
    end
    if (!src_ready) check_bit("push_tmo", src_ready, 1'b1);
    @(negedge ifclk);
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  // Checks DI on every valid cycle, so stalled cycles also prove DI is held.
  task automatic pull(input logic [15:0] e, input string nm);
    logic got = 1'b0;
    int   n   = 0;
    while (!got && n < 200) begin
      DI_ready = bp_en ? bp_pat[bp_i % 4] : 1'b1;
      bp_i++;
      if (DI_valid) begin
        check(nm, DI, e);
        got = DI_ready;
      end
      @(negedge ifclk);
      n++;
    end
    if (!got) check_bit("pull_tmo", got, 1'b1);
  endtask

  task automatic pull_csum(input logic [15:0] e);
`ifdef TX_FRAMER_CSUM_EN
    pull(e, "csum");
`else
    check_bit("no_trailer_arm", pktend_arm, 1'b1);
    check_bit("no_trailer_valid", DI_valid, 1'b0);
`endif
  endtask

  task automatic wait_arm(input int hold, input logic [15:0] exp_cnt);
    int n = 0;
    while (!pktend_arm && n < 50) begin
      @(negedge ifclk);
      n++;
    end
    check_bit("arm_seen", pktend_arm, 1'b1);
    for (int i = 0; i < hold; i++) begin
      check_bit("arm_hold", pktend_arm, 1'b1);
      check_bit("wait_valid", DI_valid, 1'b0);
      check_bit("wait_ready", src_ready, 1'b0);
      @(negedge ifclk);
    end
    PKTEND = 1'b0;
    @(negedge ifclk);
    PKTEND = 1'b1;
    check("frame_cnt", frame_cnt, exp_cnt);
    check_bit("arm_clear", pktend_arm, 1'b0);
    check_bit("ready_after", src_ready, 1'b1);
  endtask

  initial begin
    reset_n   = 1'b0;
    src_data  = 16'h0;
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_tag   = 4'h0;
    DI_ready  = 1'b0;
    PKTEND    = 1'b1;
    repeat (3) @(negedge ifclk);
    check("rst_DI", DI, 16'h0);
    check_bit("rst_DI_valid", DI_valid, 1'b0);
    check_bit("rst_arm", pktend_arm, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'h0);
    check_bit("rst_trunc", trunc, 1'b0);
    check_bit("rst_src_ready", src_ready, 1'b0);
    reset_n = 1'b1;
    @(negedge ifclk);
    check_bit("rel_edge1_ready", src_ready, 1'b0);
    @(negedge ifclk);
    check_bit("rel_edge2_ready", src_ready, 1'b1);

    // Single frame, no backpressure
    push(16'h1111, 1'b0, 4'h3);
    check_bit("saf_no_valid", DI_valid, 1'b0);
    push(16'h2222, 1'b0, 4'h3);
    push(16'h3333, 1'b1, 4'h3);
    check_bit("full_ready_low", src_ready, 1'b0);
    pull(16'hA503, "t1_hdr");
    check_bit("t1_arm_low", pktend_arm, 1'b0);
    pull(16'h0003, "t1_len");
    pull(16'h1111, "t1_d0");
    pull(16'h2222, "t1_d1");
    pull(16'h3333, "t1_d2");
    pull_csum(16'h6666);
    wait_arm(1, 16'h1);

    // Same frame under backpressure 1,0,0,1
    push(16'h1111, 1'b0, 4'h3);
    push(16'h2222, 1'b0, 4'h3);
    push(16'h3333, 1'b1, 4'h3);
    bp_en = 1'b1;
    bp_i  = 0;
    pull(16'hA503, "t2_hdr");
    pull(16'h0003, "t2_len");
    pull(16'h1111, "t2_d0");
    pull(16'h2222, "t2_d1");
    pull(16'h3333, "t2_d2");
    pull_csum(16'h6666);
    bp_en = 1'b0;
    wait_arm(1, 16'h2);
    check_bit("t2_trunc_clear", trunc, 1'b0);

    // Six words into a four-word buffer: split into L=4 and L=2
    fork
      begin
        for (int i = 0; i < 6; i++) push(16'(i), (i == 5), 4'h5);
      end
      begin
        pull(16'hA505, "t3a_hdr");
        pull(16'h0004, "t3a_len");
        pull(16'h0000, "t3a_d0");
        pull(16'h0001, "t3a_d1");
        pull(16'h0002, "t3a_d2");
        pull(16'h0003, "t3a_d3");
        pull_csum(16'h0006);
        check_bit("t3_trunc_set", trunc, 1'b1);
        wait_arm(2, 16'h3);
        pull(16'hA505, "t3b_hdr");
        pull(16'h0002, "t3b_len");
        pull(16'h0004, "t3b_d0");
        pull(16'h0005, "t3b_d1");
        pull_csum(16'h0009);
        wait_arm(2, 16'h4);
      end
    join
    check_bit("t3_trunc_sticky", trunc, 1'b1);

    // Trailer arithmetic wraps mod 2^16
    push(16'hFFFF, 1'b0, 4'h0);
    push(16'h0002, 1'b1, 4'h0);
    pull(16'hA500, "t4_hdr");
    pull(16'h0002, "t4_len");
    pull(16'hFFFF, "t4_d0");
    pull(16'h0002, "t4_d1");
    pull_csum(16'h0001);
    wait_arm(1, 16'h5);

    // Reset in the middle of DATA
    push(16'h0A0A, 1'b0, 4'h9);
    push(16'h0B0B, 1'b0, 4'h9);
    push(16'h0C0C, 1'b1, 4'h9);
    pull(16'hA509, "t5_hdr");
    pull(16'h0003, "t5_len");
    pull(16'h0A0A, "t5_d0");
    pull(16'h0B0B, "t5_d1");
    DI_ready = 1'b0;
    check_bit("t5_mid_valid", DI_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check_bit("t5_rst_valid", DI_valid, 1'b0);
    check_bit("t5_rst_arm", pktend_arm, 1'b0);
    check("t5_rst_DI", DI, 16'h0);
    check("t5_rst_cnt", frame_cnt, 16'h0);
    check_bit("t5_rst_trunc", trunc, 1'b0);
    check_bit("t5_rst_ready", src_ready, 1'b0);
    @(negedge ifclk);
    @(negedge ifclk);
    reset_n = 1'b1;
    @(negedge ifclk);
    check_bit("t5_rel1_ready", src_ready, 1'b0);
    @(negedge ifclk);
    check_bit("t5_rel2_ready", src_ready, 1'b1);
    push(16'h1234, 1'b1, 4'h6);
    pull(16'hA506, "t5n_hdr");
    pull(16'h0001, "t5n_len");
    pull(16'h1234, "t5n_d0");
    pull_csum(16'h1234);
    wait_arm(1, 16'h1);

    // Back-to-back one-word frames with a long PKTEND wait
    rises0 = arm_rises;
    push(16'h00AA, 1'b1, 4'h1);
    pull(16'hA501, "t6a_hdr");
    pull(16'h0001, "t6a_len");
    pull(16'h00AA, "t6a_d0");
    pull_csum(16'h00AA);
    wait_arm(50, 16'h2);
    push(16'h00BB, 1'b1, 4'h2);
    pull(16'hA502, "t6b_hdr");
    pull(16'h0001, "t6b_len");
    pull(16'h00BB, "t6b_d0");
    pull_csum(16'h00BB);
    wait_arm(50, 16'h3);
    check("t6_arm_rises", 16'(arm_rises - rises0), 16'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
